// File: rtl/hd_pkg.sv
// Shared constants and types for the Hamming-decoder request scheduler.
package hd_pkg;

    localparam int CW_W  = 7;
    localparam int OUT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/hd_rr_arbiter.sv
// Two-way round-robin arbiter: a lone request always wins; a contended
// request goes to the requester that was not granted last.
module hd_rr_arbiter
    import hd_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/hd_req_scheduler.sv
// Shares one combinational Hamming decoder between two requesters:
// accept a pair (round-robin), drive it to the decoder, capture and offer the result.
module hd_req_scheduler #(
    parameter int CW_W  = hd_pkg::CW_W,
    parameter int OUT_W = hd_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CW_W-1:0]  req0_cw1,
    input  logic [CW_W-1:0]  req0_cw2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CW_W-1:0]  req1_cw1,
    input  logic [CW_W-1:0]  req1_cw2,
    output logic [CW_W-1:0]  dec_cw1,
    output logic [CW_W-1:0]  dec_cw2,
    input  logic [OUT_W-1:0] dec_out_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_id,
    output logic             busy,
    output logic [7:0]       done_cnt
);

    import hd_pkg::*;

    state_e           state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [CW_W-1:0]  dec_cw1_q, dec_cw1_d;
    logic [CW_W-1:0]  dec_cw2_q, dec_cw2_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    req_id_t          out_id_q, out_id_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic [1:0] grant;
    logic       arb_en;

    // Readies are held low while reset is asserted, even if a requester is valid.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    hd_rr_arbiter u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dec_cw1_d    = dec_cw1_q;
        dec_cw2_d    = dec_cw2_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        done_cnt_d   = done_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    last_grant_d = grant[1];
                    dec_cw1_d    = grant[1] ? req1_cw1 : req0_cw1;
                    dec_cw2_d    = grant[1] ? req1_cw2 : req0_cw2;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // last_grant_q doubles as the owner id of the in-flight pair.
                out_data_d  = dec_out_n;
                out_id_d    = last_grant_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            dec_cw1_q    <= '0;
            dec_cw2_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dec_cw1_q    <= dec_cw1_d;
            dec_cw2_q    <= dec_cw2_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign dec_cw1   = dec_cw1_q;
    assign dec_cw2   = dec_cw2_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign done_cnt  = done_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hd_req_scheduler.sv
// Self-checking bench for hd_req_scheduler against a transaction-level reference model.
module tb_hd_req_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, ordy;
    logic [6:0] c01, c02, c11, c12;
    logic       req0_ready, req1_ready;
    logic [6:0] dec_cw1, dec_cw2;
    logic [5:0] dec_out_n;
    logic       out_valid, out_id, busy;
    logic [5:0] out_data;
    logic [7:0] done_cnt;

    int passed = 0;
    int total  = 0;

    // Reference model state: one transaction at most in flight.
    logic       m_busy, m_outv, m_last, m_id;
    logic [5:0] m_data;
    logic [6:0] m_cw1, m_cw2;
    logic [7:0] m_cnt;
    int         hs_cnt;
    logic [1:0] obs_rdy;
    logic       obs_ov, obs_id;
    logic [5:0] obs_data;

    always #5 clk = ~clk;

    assign dec_out_n = {1'b0, dec_cw1[4:0]} ^ {1'b0, dec_cw2[4:0]};

    hd_req_scheduler #(.CW_W(7), .OUT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req0_cw1   (c01),
        .req0_cw2   (c02),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .req1_cw1   (c11),
        .req1_cw2   (c12),
        .dec_cw1    (dec_cw1),
        .dec_cw2    (dec_cw2),
        .dec_out_n  (dec_out_n),
        .out_valid  (out_valid),
        .out_ready  (ordy),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    function automatic logic [5:0] stub(input logic [6:0] a, input logic [6:0] b);
        return {1'b0, a[4:0] ^ b[4:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        c01 = '0; c02 = '0; c11 = '0; c12 = '0;
        m_busy = 1'b0; m_outv = 1'b0; m_last = 1'b1; m_id = 1'b0;
        m_data = '0; m_cw1 = '0; m_cw2 = '0; m_cnt = '0; hs_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered at posedge+1 with inputs set; checks this cycle, advances the model, returns at next posedge+1.
    task automatic cycle_check();
        logic [1:0] eg;
        #1;
        eg = 2'b00;
        if (!m_busy) begin
            if (v0 && v1) eg = m_last ? 2'b01 : 2'b10;
            else          eg = {v1, v0};
        end
        obs_rdy = {req1_ready, req0_ready};
        obs_ov = out_valid; obs_id = out_id; obs_data = out_data;
        total++;
        if (obs_rdy !== eg) $display("FAIL ready: got %b expected %b @%0t", obs_rdy, eg, $time);
        else passed++;
        total++;
        if (busy !== m_busy) $display("FAIL busy: got %b expected %b @%0t", busy, m_busy, $time);
        else passed++;
        total++;
        if (out_valid !== m_outv) $display("FAIL out_valid: got %b expected %b @%0t", out_valid, m_outv, $time);
        else passed++;
        if (m_outv) begin
            total++;
            if (out_data !== m_data || out_id !== m_id)
                $display("FAIL result: got data %h id %b expected data %h id %b @%0t",
                         out_data, out_id, m_data, m_id, $time);
            else passed++;
        end
        total++;
        if (dec_cw1 !== m_cw1 || dec_cw2 !== m_cw2)
            $display("FAIL dec_cw: got %h/%h expected %h/%h @%0t", dec_cw1, dec_cw2, m_cw1, m_cw2, $time);
        else passed++;
        total++;
        if (done_cnt !== m_cnt) $display("FAIL done_cnt: got %0d expected %0d @%0t", done_cnt, m_cnt, $time);
        else passed++;

        if (out_valid && ordy) hs_cnt++;
        if (!m_busy) begin
            if (eg != 2'b00) begin
                m_busy = 1'b1;
                m_id   = eg[1];
                m_last = eg[1];
                m_cw1  = eg[1] ? c11 : c01;
                m_cw2  = eg[1] ? c12 : c02;
                m_data = stub(m_cw1, m_cw2);
            end
        end else if (!m_outv) begin
            m_outv = 1'b1;
        end else if (ordy) begin
            m_outv = 1'b0;
            m_busy = 1'b0;
            m_cnt  = m_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        #3;
        total++;
        if ({req1_ready, req0_ready, out_valid, busy, out_id} !== 5'b0 ||
            dec_cw1 !== 7'h00 || dec_cw2 !== 7'h00 || out_data !== 6'h00 || done_cnt !== 8'h00)
            $display("FAIL reset_values: rdy %b%b ov %b busy %b id %b cw %h/%h data %h cnt %0d expected all zero",
                     req1_ready, req0_ready, out_valid, busy, out_id, dec_cw1, dec_cw2, out_data, done_cnt);
        else passed++;
        do_reset();
        repeat (2) cycle_check();
    endtask

    task automatic test_single();
        int rdy_cycles;
        do_reset();
        rdy_cycles = 0;
        c01 = 7'h15; c02 = 7'h0A; v0 = 1'b1; ordy = 1'b1;
        cycle_check();
        if (obs_rdy == 2'b01) rdy_cycles++;
        v0 = 1'b0;
        cycle_check();
        if (obs_rdy == 2'b01) rdy_cycles++;
        total++;
        if (obs_ov !== 1'b0) $display("FAIL single_latency_drive: out_valid %b expected 0", obs_ov);
        else passed++;
        cycle_check();
        total++;
        if (obs_ov !== 1'b1 || obs_data !== 6'h1F || obs_id !== 1'b0)
            $display("FAIL single_result: ov %b data %h id %b expected 1 1f 0", obs_ov, obs_data, obs_id);
        else passed++;
        cycle_check();
        total++;
        if (done_cnt !== 8'd1 || rdy_cycles != 1)
            $display("FAIL single_done: done_cnt %0d ready_cycles %0d expected 1 1", done_cnt, rdy_cycles);
        else passed++;
    endtask

    task automatic test_contention();
        logic order[$];
        do_reset();
        c01 = 7'h15; c02 = 7'h0A; c11 = 7'h03; c12 = 7'h01;
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        repeat (12) begin
            cycle_check();
            if (obs_rdy == 2'b01) order.push_back(1'b0);
            if (obs_rdy == 2'b10) order.push_back(1'b1);
            if (obs_ov && obs_id) begin
                total++;
                if (obs_data !== 6'h02) $display("FAIL contention_req1_data: got %h expected 02", obs_data);
                else passed++;
            end
        end
        total++;
        if (order.size() != 4 || order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0 || order[3] !== 1'b1)
            $display("FAIL contention_order: got %p expected 0 1 0 1", order);
        else passed++;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [5:0] held;
        do_reset();
        c01 = 7'h4C; c02 = 7'h13; v0 = 1'b1; ordy = 1'b0;
        cycle_check();
        cycle_check();
        v1 = 1'b1;
        cycle_check();
        held = obs_data;
        repeat (10) begin
            cycle_check();
            total++;
            if (obs_data !== held || obs_rdy !== 2'b00)
                $display("FAIL backpressure_hold: data %h rdy %b expected %h 00", obs_data, obs_rdy, held);
            else passed++;
        end
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        cycle_check();
        cycle_check();
        total++;
        if (busy !== 1'b0 || done_cnt !== 8'd1 || hs_cnt != 1)
            $display("FAIL backpressure_release: busy %b cnt %0d hs %0d expected 0 1 1", busy, done_cnt, hs_cnt);
        else passed++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        c01 = 7'h7F; c02 = 7'h55; v0 = 1'b1;
        cycle_check();
        v0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dec_cw1 !== 7'h00 || dec_cw2 !== 7'h00)
            $display("FAIL reset_drive: ov %b busy %b cw %h/%h expected 0 0 00/00", out_valid, busy, dec_cw1, dec_cw2);
        else passed++;
        do_reset();
        c01 = 7'h21; c02 = 7'h12; v0 = 1'b1; ordy = 1'b0;
        cycle_check();
        v0 = 1'b0;
        cycle_check();
        cycle_check();
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_hold: ov %b busy %b expected 0 0", out_valid, busy);
        else passed++;
        do_reset();
        v0 = 1'b1; v1 = 1'b1;
        cycle_check();
        total++;
        if (obs_rdy !== 2'b01) $display("FAIL reset_first_grant: got %b expected 01", obs_rdy);
        else passed++;
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) cycle_check();
    endtask

    task automatic test_wrap_random();
        int cyc;
        do_reset();
        cyc = 0;
        while (hs_cnt < 256 && cyc < 4000) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            c01 = 7'($urandom_range(0, 127)); c02 = 7'($urandom_range(0, 127));
            c11 = 7'($urandom_range(0, 127)); c12 = 7'($urandom_range(0, 127));
            ordy = ($urandom_range(0, 3) != 0);
            cycle_check();
            cyc++;
        end
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        repeat (4) cycle_check();
        total++;
        if (hs_cnt != 256 || done_cnt !== 8'd0)
            $display("FAIL wrap: handshakes %0d done_cnt %0d expected 256 0 (cycles %0d)", hs_cnt, done_cnt, cyc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_wrap_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hd_req_scheduler.md
# hd_req_scheduler

Shares one Hamming decoder datapath between two requesters. The datapath is combinational: it takes two 7-bit code words and returns a signed 6-bit result. This block accepts a code-word pair from one requester at a time under round-robin arbitration and presents that pair to the decoder on registered outputs. It then captures the decoder result and offers it downstream on a valid/ready handshake, tagged with the requester id. It sits between the requester front-ends and the shared HD datapath.

## Interface
- Parameters:
- CW_W, 7, code word width
- OUT_W, 6, decoder result width (two's complement)
- Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 offers a pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_cw1, req0_cw2  in  CW_W  requester 0 code words
- req1_valid, req1_ready, req1_cw1, req1_cw2: same definitions for requester 1
- dec_cw1, dec_cw2  out  CW_W  registered drive to the shared decoder
- dec_out_n  in  OUT_W  combinational decoder result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  captured decoder result, passed through bit-exact
- out_id  out  1  id of the requester that owns out_data
- busy  out  1  high whenever the state is not IDLE
- done_cnt  out  8  count of completed output handshakes; wraps 255→0

## Operation
- FSM states: IDLE, DRIVE, HOLD. Reset state is IDLE.
- **IDLE**
  - If any reqX_valid is high, the arbiter picks one requester. Only the picked requester's reqX_ready is driven high, combinationally, in that cycle.
  - On the handshake, latch that requester's cw1/cw2 into dec_cw1/dec_cw2 and its id into a grant register, then go to DRIVE.
- **DRIVE**
  - The decoder settles.
  - At the clock edge: out_data ← dec_out_n, out_id ← grant id, out_valid ← 1, then go to HOLD.
- **HOLD**
  - out_valid stays high; out_data and out_id stay stable.
  - On out_valid & out_ready: out_valid ← 0, done_cnt ← done_cnt + 1, then go to IDLE.
- **Arbitration**
  - The last_grant register resets to 1, so req0 wins the first contention.
  - When both requests are valid in IDLE, grant the requester ≠ last_grant.
  - When only one request is valid, grant it regardless of last_grant.
  - last_grant updates only on an accepted request.
- **Handshake and data-hold rules**
  - reqX_ready is never high outside IDLE.
  - Requesters hold valid and data until ready; the block does not require this but samples only on the handshake cycle.
  - dec_cw1/dec_cw2 stay at the last accepted pair until the next acceptance, including while in IDLE.
- The block performs no arithmetic on out_data. Sign and width are exactly those of dec_out_n.

## Timing
- Reset values: req0_ready = 0, req1_ready = 0, dec_cw1 = dec_cw2 = 0, out_valid = 0, out_data = 0, out_id = 0, busy = 0, done_cnt = 0, last_grant = 1.
- Latency: request handshake at edge N → out_valid high after edge N+1 (one DRIVE cycle).
- Minimum period: 3 cycles per transaction when out_ready is held high (IDLE, DRIVE, HOLD).
- out_ready already high on HOLD entry: the handshake completes at the first HOLD edge.
- out_ready low: the block stays in HOLD indefinitely. Both requesters see ready = 0 throughout.
- Reset asserted mid-transaction: everything returns asynchronously to reset values, including out_valid dropping immediately. The in-flight pair is discarded and not retried.
- done_cnt at 255 followed by a handshake gives 0; there is no saturation.

## Structure
- Shared package hd_pkg holds:
  - CW_W and OUT_W constants
  - the FSM state enum (IDLE/DRIVE/HOLD)
  - the requester id type (1 bit)
- Sub-module hd_rr_arbiter: a 2-way round-robin arbiter.
  - Inputs: valid[1:0], last_grant, enable (= state IDLE).
  - Output: one-hot grant[1:0].
- The decoder itself is instantiated outside this block.

## Test plan
Bench decoder stub: dec_out_n = {1'b0, dec_cw1[4:0]} ^ {1'b0, dec_cw2[4:0]}.
- Single request: req0 pair cw1 = 7'h15, cw2 = 7'h0A, out_ready = 1 → req0_ready for 1 cycle; out_valid 2 edges later; out_data = 6'h1F, out_id = 0; done_cnt = 1.
- Contention: both valid from reset, held → grants in order 0, 1, 0, 1; req1 pair cw1 = 7'h03, cw2 = 7'h01 gives out_data = 6'h02 with out_id = 1.
- Backpressure: out_ready = 0 for 10 cycles in HOLD → out_data/out_id stable, busy = 1, both readies 0; release → one handshake, then state IDLE.
- Reset mid-op: assert rst during DRIVE → out_valid, busy, dec_cw1 and dec_cw2 go to 0 without waiting for clk; after release, req0 wins the first contention.
- Counter wrap: 256 back-to-back transactions → done_cnt reads 0; there are exactly 256 out_valid & out_ready cycles.
